// File: rtl/hough_peak_select_if.sv
// Accumulator BRAM read bus between the peak selector and the BRAM.
// master drives accum_rd_addr; slave returns accum_rd_data.
interface hough_peak_select_if #(
   parameter int ADDR_BITS = 19,
   parameter int VOTE_BITS = 16
);
   logic [ADDR_BITS-1:0] accum_rd_addr;
   logic [VOTE_BITS-1:0] accum_rd_data;

   modport master (
      output accum_rd_addr,
      input  accum_rd_data
   );

   modport slave (
      input  accum_rd_addr,
      output accum_rd_data
   );
endinterface

// File: rtl/hough_peak_select.sv
// Scans the Hough accumulator for the strongest left/right lane cells.
// Ports: clock, reset (sync, active-low), start, accum (BRAM read bus),
// busy, left/right rho/theta/found, peaks_done (one-cycle pulse).
module hough_peak_select #(
   parameter int RHO_RANGE       = 2121,
   parameter int RHO_OFFSET      = 1060,
   parameter int THETA_RANGE     = 180,
   parameter int THETA_BITS      = 9,
   parameter int VOTE_BITS       = 16,
   parameter int LEFT_THETA_MIN  = 20,
   parameter int LEFT_THETA_MAX  = 70,
   parameter int RIGHT_THETA_MIN = 110,
   parameter int RIGHT_THETA_MAX = 160,
   parameter int VOTE_THRESHOLD  = 50,
   parameter int ADDR_BITS       = $clog2(RHO_RANGE*THETA_RANGE)
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         start,
   hough_peak_select_if.master          accum,
   output logic                         busy,
   output logic signed [15:0]           left_rho_out,
   output logic        [THETA_BITS-1:0] left_theta_out,
   output logic                         left_found,
   output logic signed [15:0]           right_rho_out,
   output logic        [THETA_BITS-1:0] right_theta_out,
   output logic                         right_found,
   output logic                         peaks_done
);
   localparam int RB = $clog2(RHO_RANGE);

   // Each window is a contiguous address range, so a plain
   // incrementing counter walks theta-major / rho-minor order.
   localparam logic [ADDR_BITS-1:0] L_FIRST =
      ADDR_BITS'(LEFT_THETA_MIN * RHO_RANGE);
   localparam logic [ADDR_BITS-1:0] L_LAST =
      ADDR_BITS'((LEFT_THETA_MAX + 1) * RHO_RANGE - 1);
   localparam logic [ADDR_BITS-1:0] R_FIRST =
      ADDR_BITS'(RIGHT_THETA_MIN * RHO_RANGE);
   localparam logic [ADDR_BITS-1:0] R_LAST =
      ADDR_BITS'((RIGHT_THETA_MAX + 1) * RHO_RANGE - 1);
   localparam logic [RB-1:0] RHO_LAST = RB'(RHO_RANGE - 1);
   localparam logic [THETA_BITS-1:0] L_TH0 = THETA_BITS'(LEFT_THETA_MIN);
   localparam logic [THETA_BITS-1:0] R_TH0 = THETA_BITS'(RIGHT_THETA_MIN);
   localparam logic [VOTE_BITS-1:0] THRESH = VOTE_BITS'(VOTE_THRESHOLD);

   typedef enum logic [2:0] {
      IDLE, SCAN_LEFT, DRAIN_LEFT, SCAN_RIGHT, DRAIN_RIGHT, DONE
   } state_t;

   state_t                state;
   logic [ADDR_BITS-1:0]  addr_cnt;
   logic [THETA_BITS-1:0] theta_cnt;
   logic [RB-1:0]         rho_cnt;

   // Tag travels with the registered address; the data returned for
   // it is compared in the following cycle.
   logic                  tag_valid;
   logic                  tag_right;
   logic [THETA_BITS-1:0] tag_theta;
   logic [RB-1:0]         tag_rho;

   logic [VOTE_BITS-1:0]  l_votes, r_votes;
   logic [THETA_BITS-1:0] l_theta, r_theta;
   logic [RB-1:0]         l_rho, r_rho;

   logic                  hit_l, hit_r;
   logic [VOTE_BITS-1:0]  r_votes_fin;
   logic [THETA_BITS-1:0] r_theta_fin;
   logic [RB-1:0]         r_rho_fin;
   logic                  l_ok, r_ok;

   // Strict greater-than keeps the earliest cell on ties.
   assign hit_l = tag_valid && !tag_right
               && (accum.accum_rd_data > l_votes);
   assign hit_r = tag_valid && tag_right
               && (accum.accum_rd_data > r_votes);

   // Right lane's last compare lands in DRAIN_RIGHT, the same edge
   // that loads the outputs, so fold it in here.
   assign r_votes_fin = hit_r ? accum.accum_rd_data : r_votes;
   assign r_theta_fin = hit_r ? tag_theta : r_theta;
   assign r_rho_fin   = hit_r ? tag_rho : r_rho;
   assign l_ok        = (l_votes >= THRESH);
   assign r_ok        = (r_votes_fin >= THRESH);

   function automatic logic signed [15:0] to_rho(
      input logic [RB-1:0] idx
   );
      return $signed(16'(idx) - 16'(RHO_OFFSET));
   endfunction

   always_ff @(posedge clock) begin
      if (!reset) begin
         state               <= IDLE;
         busy                <= 1'b0;
         peaks_done          <= 1'b0;
         left_rho_out        <= '0;
         left_theta_out      <= '0;
         left_found          <= 1'b0;
         right_rho_out       <= '0;
         right_theta_out     <= '0;
         right_found         <= 1'b0;
         accum.accum_rd_addr <= '0;
         addr_cnt            <= '0;
         theta_cnt           <= '0;
         rho_cnt             <= '0;
         tag_valid           <= 1'b0;
         tag_right           <= 1'b0;
         tag_theta           <= '0;
         tag_rho             <= '0;
         l_votes             <= '0;
         l_theta             <= '0;
         l_rho               <= '0;
         r_votes             <= '0;
         r_theta             <= '0;
         r_rho               <= '0;
      end else begin
         peaks_done <= 1'b0;
         if (hit_l) begin
            l_votes <= accum.accum_rd_data;
            l_theta <= tag_theta;
            l_rho   <= tag_rho;
         end
         if (hit_r) begin
            r_votes <= accum.accum_rd_data;
            r_theta <= tag_theta;
            r_rho   <= tag_rho;
         end
         unique case (state)
            IDLE: begin
               if (start) begin
                  state     <= SCAN_LEFT;
                  busy      <= 1'b1;
                  addr_cnt  <= L_FIRST;
                  theta_cnt <= L_TH0;
                  rho_cnt   <= '0;
                  l_votes   <= '0;
                  l_theta   <= '0;
                  l_rho     <= '0;
               end
            end
            SCAN_LEFT, SCAN_RIGHT: begin
               accum.accum_rd_addr <= addr_cnt;
               tag_valid           <= 1'b1;
               tag_right           <= (state == SCAN_RIGHT);
               tag_theta           <= theta_cnt;
               tag_rho             <= rho_cnt;
               addr_cnt            <= addr_cnt + 1'b1;
               if (rho_cnt == RHO_LAST) begin
                  rho_cnt   <= '0;
                  theta_cnt <= theta_cnt + 1'b1;
               end else begin
                  rho_cnt <= rho_cnt + 1'b1;
               end
               if (state == SCAN_LEFT && addr_cnt == L_LAST)
                  state <= DRAIN_LEFT;
               if (state == SCAN_RIGHT && addr_cnt == R_LAST)
                  state <= DRAIN_RIGHT;
            end
            DRAIN_LEFT: begin
               state     <= SCAN_RIGHT;
               tag_valid <= 1'b0;
               addr_cnt  <= R_FIRST;
               theta_cnt <= R_TH0;
               rho_cnt   <= '0;
               r_votes   <= '0;
               r_theta   <= '0;
               r_rho     <= '0;
            end
            DRAIN_RIGHT: begin
               state           <= DONE;
               tag_valid       <= 1'b0;
               peaks_done      <= 1'b1;
               left_found      <= l_ok;
               left_rho_out    <= l_ok ? to_rho(l_rho) : '0;
               left_theta_out  <= l_ok ? l_theta : '0;
               right_found     <= r_ok;
               right_rho_out   <= r_ok ? to_rho(r_rho_fin) : '0;
               right_theta_out <= r_ok ? r_theta_fin : '0;
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_hough_peak_select.sv
// Bench for hough_peak_select with a reduced rho range.
// Directed lane cases, randomized contents vs. a reference scan.
module tb_hough_peak_select;
   localparam int RR  = 21;
   localparam int RO  = 10;
   localparam int TR  = 180;
   localparam int AB  = $clog2(RR*TR);
   localparam int NL  = (70 - 20 + 1) * RR;
   localparam int NR  = (160 - 110 + 1) * RR;
   localparam int LAT = NL + NR + 3;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0;
   logic busy, peaks_done;
   logic signed [15:0] left_rho_out, right_rho_out;
   logic [8:0] left_theta_out, right_theta_out;
   logic left_found, right_found;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] mem [RR*TR];

   hough_peak_select_if #(.ADDR_BITS(AB), .VOTE_BITS(16)) bus ();

   // BRAM whose address register is the DUT's address output
   assign bus.accum_rd_data = mem[bus.accum_rd_addr];

   hough_peak_select #(
      .RHO_RANGE(RR),
      .RHO_OFFSET(RO),
      .THETA_RANGE(TR)
   ) dut (
      .clock(clk),
      .reset(reset),
      .start(start),
      .accum(bus.master),
      .busy(busy),
      .left_rho_out(left_rho_out),
      .left_theta_out(left_theta_out),
      .left_found(left_found),
      .right_rho_out(right_rho_out),
      .right_theta_out(right_theta_out),
      .right_found(right_found),
      .peaks_done(peaks_done)
   );

   always #5 clk = ~clk;

   function automatic logic [51:0] outs();
      return {left_found, left_rho_out, left_theta_out,
              right_found, right_rho_out, right_theta_out};
   endfunction

   function automatic logic [51:0] pk(
      input bit lf, input int lr, input int lt,
      input bit rf, input int rr, input int rt
   );
      return {lf, 16'(lr), 9'(lt), rf, 16'(rr), 9'(rt)};
   endfunction

   // Brute-force search of each window for its first maximal cell.
   function automatic logic [51:0] model();
      logic [25:0] lane [2];
      int lo, hi, bv, bt, br;
      for (int l = 0; l < 2; l++) begin
         lo = (l == 1) ? 110 : 20;
         hi = (l == 1) ? 160 : 70;
         bv = 0; bt = 0; br = 0;
         for (int t = lo; t <= hi; t++)
            for (int p = 0; p < RR; p++)
               if (int'(mem[t*RR+p]) > bv) begin
                  bv = int'(mem[t*RR+p]);
                  bt = t;
                  br = p;
               end
         if (bv >= 50) lane[l] = {1'b1, 16'(br - RO), 9'(bt)};
         else          lane[l] = '0;
      end
      return {lane[0], lane[1]};
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < RR*TR; i++) mem[i] = '0;
   endtask

   task automatic put(input int t, input int p, input int v);
      mem[t*RR+p] = 16'(v);
   endtask

   task automatic run_scan(output int lat, output int bcyc);
      lat = -1;
      bcyc = 0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int c = 1; c <= LAT + 500; c++) begin
         @(negedge clk);
         if (busy) bcyc++;
         if (peaks_done) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_vec++;
      if ({outs(), busy, peaks_done, bus.accum_rd_addr} !== '0) begin
         n_err++;
         $display("FAIL reset_state got %h want 0",
                  {outs(), busy, peaks_done, bus.accum_rd_addr});
      end
      #1 reset = 1'b1;
   endtask

   task automatic test_all_zero();
      int lat, bc;
      clear_mem();
      run_scan(lat, bc);
      n_vec++;
      if (lat !== LAT) begin
         n_err++;
         $display("FAIL zero_latency got %0d want %0d", lat, LAT);
      end
      n_vec++;
      if (bc !== LAT) begin
         n_err++;
         $display("FAIL zero_busy got %0d want %0d", bc, LAT);
      end
      n_vec++;
      if (outs() !== '0) begin
         n_err++;
         $display("FAIL zero_outputs got %h want 0", outs());
      end
      @(negedge clk);
      n_vec++;
      if ({peaks_done, busy} !== 2'b00) begin
         n_err++;
         $display("FAIL done_pulse got %b want 00", {peaks_done, busy});
      end
   endtask

   task automatic test_single();
      int lat, bc;
      logic [51:0] exp;
      clear_mem();
      put(45, 15, 200);
      exp = pk(1, 5, 45, 0, 0, 0);
      run_scan(lat, bc);
      n_vec++;
      if (lat !== LAT || outs() !== exp) begin
         n_err++;
         $display("FAIL single lat %0d out %h want %0d %h",
                  lat, outs(), LAT, exp);
      end
   endtask

   task automatic test_ties();
      int lat, bc;
      logic [51:0] exp;
      clear_mem();
      put(30, 10, 200);
      put(30, 15, 200);
      put(40, 3, 200);
      exp = pk(1, 0, 30, 0, 0, 0);
      run_scan(lat, bc);
      n_vec++;
      if (lat !== LAT || outs() !== exp) begin
         n_err++;
         $display("FAIL ties lat %0d out %h want %0d %h",
                  lat, outs(), LAT, exp);
      end
   endtask

   task automatic test_threshold();
      int lat, bc;
      logic [51:0] exp;
      clear_mem();
      put(20, 5, 49);
      put(160, 0, 50);
      exp = pk(0, 0, 0, 1, -10, 160);
      run_scan(lat, bc);
      n_vec++;
      if (lat !== LAT || outs() !== exp) begin
         n_err++;
         $display("FAIL threshold lat %0d out %h want %0d %h",
                  lat, outs(), LAT, exp);
      end
   endtask

   task automatic test_out_of_window();
      int lat, bc;
      logic [51:0] exp;
      clear_mem();
      put(90, 4, 1000);
      put(19, 4, 1000);
      put(71, 3, 1000);
      put(109, 8, 1000);
      put(161, 0, 1000);
      put(110, 20, 60);
      exp = pk(0, 0, 0, 1, 10, 110);
      run_scan(lat, bc);
      n_vec++;
      if (lat !== LAT || outs() !== exp) begin
         n_err++;
         $display("FAIL out_of_window lat %0d out %h want %0d %h",
                  lat, outs(), LAT, exp);
      end
   endtask

   task automatic test_reset_mid();
      int seen;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (500) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_vec++;
      if ({outs(), busy, peaks_done} !== '0) begin
         n_err++;
         $display("FAIL mid_reset got %h want 0",
                  {outs(), busy, peaks_done});
      end
      reset = 1'b1;
      seen = 0;
      for (int c = 0; c < LAT + 50; c++) begin
         @(negedge clk);
         if (peaks_done || busy) seen++;
      end
      n_vec++;
      if (seen !== 0) begin
         n_err++;
         $display("FAIL mid_reset_quiet got %0d want 0", seen);
      end
   endtask

   task automatic test_random();
      int lat, bc;
      logic [51:0] exp;
      for (int k = 0; k < 4; k++) begin
         clear_mem();
         if (k[0]) begin
            for (int i = 0; i < RR*TR; i++)
               mem[i] = 16'($urandom_range(0, 300));
         end else begin
            for (int j = 0; j < 6; j++)
               put($urandom_range(15, 165), $urandom_range(0, RR-1),
                   $urandom_range(1, 120));
         end
         exp = model();
         run_scan(lat, bc);
         n_vec++;
         if (lat !== LAT || outs() !== exp) begin
            n_err++;
            $display("FAIL random%0d lat %0d out %h want %0d %h",
                     k, lat, outs(), LAT, exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      int lat, extra;
      logic [51:0] exp;
      clear_mem();
      put(70, 20, 77);
      put(110, 0, 300);
      put(135, 7, 300);
      exp = model();
      lat = -1;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int c = 1; c <= LAT + 500; c++) begin
         @(negedge clk);
         start = (c == 700);
         if (peaks_done) begin
            lat = c;
            break;
         end
      end
      start = 1'b0;
      n_vec++;
      if (lat !== LAT || outs() !== exp) begin
         n_err++;
         $display("FAIL restart lat %0d out %h want %0d %h",
                  lat, outs(), LAT, exp);
      end
      extra = 0;
      for (int c = 0; c < LAT + 50; c++) begin
         @(negedge clk);
         if (peaks_done) extra++;
      end
      n_vec++;
      if (extra !== 0) begin
         n_err++;
         $display("FAIL restart_extra got %0d want 0", extra);
      end
   endtask

   initial begin
      clear_mem();
      test_reset();
      test_all_zero();
      test_single();
      test_ties();
      test_threshold();
      test_out_of_window();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
